// File: rtl/wb_stream_burst_writer.sv
// Stream-to-wishbone frame writer: buffers a valid/ready word stream in a small FIFO
// and writes one frame to consecutive byte addresses using incrementing bursts.
module wb_stream_burst_writer #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic [AW-1:0]   base_addr_i,
   input  logic [23:0]     frame_words_i,
   input  logic            start_i,
   output logic            busy_o,
   output logic            done_o,
   input  logic            s_valid_i,
   input  logic [DW-1:0]   s_data_i,
   output logic            s_ready_o,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic            wb_we_o,
   output logic [2:0]      wb_cti_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   input  logic            wb_ack_i
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BW = $clog2(BURST_LEN + 1);

   localparam logic [AW-1:0] AddrStep  = AW'(DW / 8);
   localparam logic [23:0]   BurstLen  = 24'(BURST_LEN);
   localparam logic [CW-1:0] FifoDepth = CW'(FIFO_DEPTH);
   localparam logic [2:0]    CtiIncr   = 3'b010;
   localparam logic [2:0]    CtiEnd    = 3'b111;

   typedef enum logic [1:0] {StIdle, StWait, StBurst, StDone} state_e;

   state_e          state_q;
   logic [DW-1:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   fifo_cnt_q;
   logic [23:0]     acc_cnt_q, rem_cnt_q;
   logic [23:0]     burst_n;
   logic [BW-1:0]   beat_cnt_q;
   logic [AW-1:0]   adr_q;
   logic [2:0]      cti_q;
   logic            cyc_q, busy_q, done_q;
   logic            fifo_full, push, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Full is taken from the registered count, so a same-cycle pop never re-opens ready.
   assign fifo_full = (fifo_cnt_q == FifoDepth);
   assign s_ready_o = busy_q & ~fifo_full & (acc_cnt_q != '0);
   assign push      = s_valid_i & s_ready_o;
   assign pop       = (state_q == StBurst) & wb_ack_i;
   assign burst_n   = (rem_cnt_q < BurstLen) ? rem_cnt_q : BurstLen;

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge wb_clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= s_data_i;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop) begin
            fifo_cnt_q <= fifo_cnt_q + CW'(1);
         end else if (pop && !push) begin
            fifo_cnt_q <= fifo_cnt_q - CW'(1);
         end
      end
   end

   // Frame sequencer with registered bus and status outputs.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q    <= StIdle;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cyc_q      <= 1'b0;
         cti_q      <= '0;
         adr_q      <= '0;
         acc_cnt_q  <= '0;
         rem_cnt_q  <= '0;
         beat_cnt_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (push) begin
            acc_cnt_q <= acc_cnt_q - 24'd1;
         end
         unique case (state_q)
            // busy_o is low in both states, so a start is taken in either.
            StIdle, StDone: begin
               state_q <= StIdle;
               if (start_i) begin
                  adr_q     <= base_addr_i;
                  acc_cnt_q <= frame_words_i;
                  rem_cnt_q <= frame_words_i;
                  if (frame_words_i == '0) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StWait;
                     busy_q  <= 1'b1;
                  end
               end
            end
            StWait: begin
               if (24'(fifo_cnt_q) >= burst_n) begin
                  beat_cnt_q <= BW'(burst_n);
                  cyc_q      <= 1'b1;
                  cti_q      <= (burst_n == 24'd1) ? CtiEnd : CtiIncr;
                  state_q    <= StBurst;
               end
            end
            StBurst: begin
               if (wb_ack_i) begin
                  adr_q      <= adr_q + AddrStep;
                  rem_cnt_q  <= rem_cnt_q - 24'd1;
                  beat_cnt_q <= beat_cnt_q - BW'(1);
                  if (beat_cnt_q == BW'(1)) begin
                     cyc_q <= 1'b0;
                     cti_q <= '0;
                     if (rem_cnt_q == 24'd1) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q <= StWait;
                     end
                  end else begin
                     cti_q <= (beat_cnt_q == BW'(2)) ? CtiEnd : CtiIncr;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = cyc_q ? mem_q[rd_ptr_q] : '0;
   assign wb_sel_o = {(DW/8){cyc_q}};
   assign wb_we_o  = cyc_q;
   assign wb_cti_o = cti_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_stream_burst_writer.sv
// Randomized bench for wb_stream_burst_writer with a frame-level reference model.
module tb_wb_stream_burst_writer;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BL = 4;
   localparam int FD = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [23:0]   frame_words = '0;
   logic          start = 1'b0;
   logic          busy, done;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready;
   logic [AW-1:0] wb_adr;
   logic [DW-1:0] wb_dat;
   logic [3:0]    wb_sel;
   logic          wb_we, wb_cyc, wb_stb;
   logic [2:0]    wb_cti;
   logic          wb_ack = 1'b0;

   always #5 clk = ~clk;

   wb_stream_burst_writer #(
      .AW(AW), .DW(DW), .BURST_LEN(BL), .FIFO_DEPTH(FD)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .base_addr_i  (base_addr),
      .frame_words_i(frame_words),
      .start_i      (start),
      .busy_o       (busy),
      .done_o       (done),
      .s_valid_i    (s_valid),
      .s_data_i     (s_data),
      .s_ready_o    (s_ready),
      .wb_adr_o     (wb_adr),
      .wb_dat_o     (wb_dat),
      .wb_sel_o     (wb_sel),
      .wb_we_o      (wb_we),
      .wb_cti_o     (wb_cti),
      .wb_cyc_o     (wb_cyc),
      .wb_stb_o     (wb_stb),
      .wb_ack_i     (wb_ack)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state (frame-level view of the expected bus traffic).
   bit            m_busy = 0, m_done = 0;
   int            m_occ = 0, m_k = 0, m_acc = 0, m_frame = 0;
   logic [31:0]   m_base = '0;
   logic [31:0]   m_data[$];
   bit            gap_exp = 0, cont_exp = 0, prev_wait = 0, rst_was = 0, last_push = 0;
   logic [31:0]   prev_adr, prev_dat;
   logic [2:0]    prev_cti;
   int            done_seen = 0, push_seen = 0;

   // Driver configuration.
   bit            s_en = 0;
   int            prob = 100, waits = 0, wcnt = 0;
   logic [31:0]   fixed_q[$];

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_occ = 0; m_k = 0; m_acc = 0; m_frame = 0;
      m_data.delete();
      gap_exp = 0; cont_exp = 0; prev_wait = 0;
   endtask

   task automatic monitor();
      bit         push, pop, exp_fin, acc_start, nd;
      logic [2:0] exp_cti;
      if (!rst_was) begin
         check_eq("rst_adr", wb_adr, 32'h0);
         check_eq("rst_dat", wb_dat, 32'h0);
         check_eq("rst_cti", 32'(wb_cti), 32'h0);
      end
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("done", 32'(done), 32'(m_done));
      check_eq("s_ready", 32'(s_ready), 32'(m_busy && m_occ < FD && m_acc < m_frame));
      check_eq("stb_eq_cyc", 32'(wb_stb), 32'(wb_cyc));
      check_eq("we_eq_cyc", 32'(wb_we), 32'(wb_cyc));
      check_eq("sel", 32'(wb_sel), wb_cyc ? 32'hF : 32'h0);
      check_eq("extra_beat", 32'(wb_cyc && m_k >= m_frame), 32'h0);
      if (gap_exp)  check_eq("burst_gap", 32'(wb_cyc), 32'h0);
      if (cont_exp) check_eq("burst_cont", 32'(wb_cyc), 32'h1);
      if (prev_wait) begin
         check_eq("stb_held", 32'(wb_cyc), 32'h1);
         check_eq("hold_adr", wb_adr, prev_adr);
         check_eq("hold_dat", wb_dat, prev_dat);
         check_eq("hold_cti", 32'(wb_cti), 32'(prev_cti));
      end
      push = s_valid && s_ready;
      pop  = wb_cyc && wb_ack;
      exp_fin = 0;
      if (pop) begin
         exp_fin = ((m_k % BL) == BL - 1) || (m_k == m_frame - 1);
         exp_cti = exp_fin ? 3'b111 : 3'b010;
         check_eq("beat_adr", wb_adr, m_base + 32'(m_k) * 32'd4);
         if (m_k < m_data.size()) check_eq("beat_dat", wb_dat, m_data[m_k]);
         else check_eq("beat_dat_avail", 32'h0, 32'h1);
         check_eq("beat_cti", 32'(wb_cti), 32'(exp_cti));
      end
      if (done) done_seen++;
      if (push) push_seen++;
      gap_exp   = pop && exp_fin;
      cont_exp  = pop && !exp_fin;
      prev_wait = wb_cyc && !wb_ack;
      prev_adr  = wb_adr;
      prev_dat  = wb_dat;
      prev_cti  = wb_cti;
      last_push = push;
      acc_start = start && !m_busy;
      nd = 0;
      if (push) begin
         m_data.push_back(s_data);
         m_acc++;
         m_occ++;
      end
      if (pop) begin
         m_occ--;
         m_k++;
         if (m_k == m_frame) begin
            m_busy = 0;
            nd = 1;
         end
      end
      if (acc_start) begin
         m_base = base_addr; m_frame = int'(frame_words); m_acc = 0; m_k = 0;
         m_data.delete();
         if (frame_words == '0) nd = 1;
         else m_busy = 1;
      end
      m_done = nd;
      if (!rst_n) model_reset();
      rst_was = rst_n;
   endtask

   task automatic drive();
      if (wb_cyc) begin
         if (wcnt == 0) begin
            wb_ack = 1'b1;
            wcnt = waits;
         end else begin
            wb_ack = 1'b0;
            wcnt--;
         end
      end else begin
         wb_ack = 1'b0;
         wcnt = waits;
      end
      if (!s_valid || last_push) begin
         if (s_en && $urandom_range(99) < prob) begin
            s_valid = 1'b1;
            s_data  = (fixed_q.size() != 0) ? fixed_q.pop_front() : $urandom;
         end else begin
            s_valid = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic stream_off();
      s_en = 0;
      s_valid = 1'b0;
      last_push = 0;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic run_frame(input logic [31:0] b, input int f, input int w, input int p);
      int budget;
      waits = w; prob = p; s_en = 1;
      base_addr = b; frame_words = 24'(f);
      start = 1'b1;
      tick();
      start = 1'b0;
      budget = 0;
      while (!m_done && budget < 3000) begin
         // Spurious starts while busy must be ignored.
         start = m_busy && ($urandom_range(7) == 0);
         base_addr = $urandom;
         frame_words = 24'($urandom_range(1, 50));
         tick();
         budget++;
      end
      start = 1'b0;
      check_eq("frame_timeout", 32'(m_done), 32'h1);
      if (!m_done) do_reset(2);
      else tick();
   endtask

   initial begin
      int d0, p0, budget;
      // Reset held 5 cycles, then released.
      repeat (5) tick();
      rst_n = 1'b1;
      tick();
      check_eq("t1_busy", 32'(busy), 32'h0);
      check_eq("t1_done", 32'(done), 32'h0);
      check_eq("t1_ready", 32'(s_ready), 32'h0);
      check_eq("t1_cyc", 32'(wb_cyc), 32'h0);

      // Single 4-beat burst with known data, zero-wait slave.
      stream_off();
      fixed_q = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f00};
      d0 = done_seen;
      run_frame(32'h0, 4, 0, 100);
      check_eq("t2_done_pulses", 32'(done_seen - d0), 32'h1);

      // Frame of 6 splits 4+2; the 7th offered word stays unaccepted.
      stream_off();
      p0 = push_seen;
      run_frame(32'h100, 6, 0, 100);
      repeat (5) tick();
      check_eq("t3_words_accepted", 32'(push_seen - p0), 32'd6);

      // Single-word frame, then an empty frame.
      stream_off();
      run_frame(32'h2000, 1, 1, 100);
      stream_off();
      d0 = done_seen;
      run_frame(32'h3000, 0, 0, 100);
      check_eq("t4_zero_done", 32'(done_seen - d0), 32'h1);

      // Slow slave with a continuous stream fills the FIFO.
      stream_off();
      run_frame(32'h4000, 20, 3, 100);

      // Reset during beat 2 of a burst, then a fresh frame.
      stream_off();
      waits = 0; prob = 100; s_en = 1;
      base_addr = 32'h5000; frame_words = 24'd8;
      start = 1'b1;
      tick();
      start = 1'b0;
      budget = 0;
      while (!(m_k == 1 && wb_cyc) && budget < 200) begin
         tick();
         budget++;
      end
      check_eq("t6_reach_beat2", 32'(budget < 200), 32'h1);
      rst_n = 1'b0;
      tick();
      check_eq("t6_cyc_dropped", 32'(wb_cyc), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      stream_off();
      run_frame(32'h6000, 5, 1, 100);

      // Address wrap.
      stream_off();
      run_frame(32'hFFFF_FFF0, 8, 0, 80);

      // Randomized frames.
      for (int i = 0; i < 10; i++) begin
         stream_off();
         run_frame($urandom, $urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(30, 100));
      end

      stream_off();
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
